dbu_mem_loader: RTL and testbench

Debug write-side companion to the debug display unit. Accepts a byte stream over a valid/ready handshake, assembles it little-endian into DATA_WIDTH-bit words, and writes them into the CPU data memory debug write port at consecutive addresses from a base. While loading, it holds the CPU. It sits between a byte source (UART receiver or switch/button front-end) and the memory debug port.

---
 rtl/dbu_mem_loader_if.sv | 23 ++
 rtl/dbu_mem_loader.sv | 121 ++++++++++++
 tb/tb_dbu_mem_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbu_mem_loader_if.sv
// Byte-stream handshake and memory debug write port for the debug memory loader.
// The slave modport is the loader's view; the master modport is the byte source / memory side.
interface dbu_mem_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_d;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_a, mem_d
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_a, mem_d
  );
endinterface

// File: rtl/dbu_mem_loader.sv
// Debug memory loader: assembles a little-endian byte stream into words and writes them
// at consecutive addresses from a base while holding the CPU.
module dbu_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] len,
  dbu_mem_loader_if.slave       bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cnt
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  assign cnt_inc   = cnt_q + 1'b1;
  assign bus.mem_a = base_q + cnt_q;
  assign bus.mem_d = word_q;
  assign busy      = (state_q != IDLE);
  assign cnt       = cnt_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    idx_d        = idx_q;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    cpu_hold     = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // start takes priority over abort here; abort alone is a no-op
        if (start) begin
          base_d  = base_a;
          len_d   = len;
          cnt_d   = '0;
          idx_d   = '0;
          word_d  = '0;
          state_d = (len == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        cpu_hold     = 1'b1;
        bus.in_ready = !abort;
        if (abort) begin
          word_d  = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (bus.in_valid) begin
          word_d[{idx_q, 3'b000} +: 8] = bus.in_data;
          if (idx_q == IDX_W'(BYTES - 1)) begin
            idx_d   = '0;
            state_d = WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WRITE: begin
        cpu_hold = 1'b1;
        if (abort) begin
          word_d  = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          bus.mem_we = 1'b1;
          cnt_d      = cnt_inc;
          state_d    = (cnt_inc == len_q) ? DONE : RECV;
        end
      end
      DONE: begin
        cpu_hold = 1'b1;
        done     = !abort;
        if (abort) begin
          word_d = '0;
          idx_d  = '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dbu_mem_loader.sv
// Self-checking bench for dbu_mem_loader: directed scenarios plus randomized loads
// compared against a word/address list computed directly from the byte stream.
module tb_dbu_mem_loader;
  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] base_a, len;
  logic       cpu_hold, busy, done;
  logic [7:0] cnt;

  int vectors = 0;
  int miscompares = 0;

  dbu_mem_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus();

  dbu_mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_a(base_a), .len(len), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // Passive monitor: everything observed at the falling edge.
  logic [7:0]  wr_a[$];
  logic [31:0] wr_d[$];
  logic [7:0]  acc[$];
  int n_done = 0, n_hold_err = 0, n_rdy_err = 0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_a.push_back(bus.mem_a);
      wr_d.push_back(bus.mem_d);
    end
    if (done === 1'b1) n_done++;
    if (bus.in_valid && bus.in_ready === 1'b1) acc.push_back(bus.in_data);
    if (cpu_hold !== busy) n_hold_err++;
    if (bus.in_ready === 1'b1 && (bus.mem_we === 1'b1 || abort)) n_rdy_err++;
  end

  function automatic logic [31:0] exp_word(input logic [7:0] b[$], input int i);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w = w | (32'(b[4*i+k]) << (8*k));
    return w;
  endfunction

  task automatic do_start(input logic [7:0] b, input logic [7:0] l);
    start = 1'b1; base_a = b; len = l;
    @(posedge clk); #1;
    start = 1'b0; base_a = $urandom; len = $urandom;
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid
  task automatic drive_bytes(input logic [7:0] b[$], input int mode);
    int p, guard;
    logic v;
    p = 0; guard = 0; v = 1'b0;
    while (p < b.size() && guard < 2000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ~v : 1'($urandom_range(0, 1));
      bus.in_valid = v;
      bus.in_data  = v ? b[p] : 8'($urandom);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready === 1'b1) p++;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_a = '0; len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.mem_we, bus.mem_a, bus.mem_d, cpu_hold, busy, done, cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b we=%b a=%h d=%h hold=%b busy=%b done=%b cnt=%h required all 0",
               bus.in_ready, bus.mem_we, bus.mem_a, bus.mem_d, cpu_hold, busy, done, cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input int mode, input string nm);
    logic [7:0] b[$];
    int w0, d0, h0, r0, a0;
    bit ok;
    b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    w0 = wr_a.size(); d0 = n_done; h0 = n_hold_err; r0 = n_rdy_err; a0 = acc.size();
    do_start(8'h10, 8'd2);
    drive_bytes(b, mode);
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL %s_idle busy=%b required 0", nm, busy); end
    vectors++;
    if (wr_a.size() - w0 != 2) begin
      miscompares++; $display("FAIL %s_nwrites got %0d required 2", nm, wr_a.size() - w0);
    end else begin
      vectors++;
      if (wr_a[w0] !== 8'h10 || wr_d[w0] !== 32'h12345678) begin
        miscompares++; $display("FAIL %s_wr0 got %h@%h required 12345678@10", nm, wr_d[w0], wr_a[w0]);
      end
      vectors++;
      if (wr_a[w0+1] !== 8'h11 || wr_d[w0+1] !== 32'hDEADBEEF) begin
        miscompares++; $display("FAIL %s_wr1 got %h@%h required deadbeef@11", nm, wr_d[w0+1], wr_a[w0+1]);
      end
    end
    vectors++;
    if (n_done - d0 != 1) begin miscompares++; $display("FAIL %s_done got %0d pulses required 1", nm, n_done - d0); end
    vectors++;
    if (cnt !== 8'd2) begin miscompares++; $display("FAIL %s_cnt got %0d required 2", nm, cnt); end
    vectors++;
    if (n_hold_err != h0 || n_rdy_err != r0) begin
      miscompares++; $display("FAIL %s_hold_ready got %0d/%0d bad cycles required 0/0", nm, n_hold_err - h0, n_rdy_err - r0);
    end
    vectors++;
    if (acc.size() - a0 != 8) begin
      miscompares++; $display("FAIL %s_accepted got %0d bytes required 8", nm, acc.size() - a0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (acc[a0+i] !== b[i]) begin
          miscompares++; $display("FAIL %s_byte%0d got %h required %h", nm, i, acc[a0+i], b[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b[$];
    int w0;
    bit ok;
    b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    w0 = wr_a.size();
    do_start(8'hFF, 8'd2);
    drive_bytes(b, 0);
    wait_idle(ok);
    vectors++;
    if (!ok || wr_a.size() - w0 != 2) begin
      miscompares++; $display("FAIL wrap_nwrites got %0d required 2", wr_a.size() - w0);
    end else begin
      vectors++;
      if ({wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]} !== {8'hFF, 32'h1, 8'h00, 32'h2}) begin
        miscompares++;
        $display("FAIL wrap_writes got %h@%h %h@%h required 00000001@ff 00000002@00",
                 wr_d[w0], wr_a[w0], wr_d[w0+1], wr_a[w0+1]);
      end
    end
  endtask

  task automatic test_zero_len();
    int w0, a0;
    w0 = wr_a.size(); a0 = acc.size();
    do_start(8'h40, 8'd0);
    @(negedge clk);
    vectors++;
    if ({done, busy, bus.in_ready, bus.mem_we, cnt} !== {3'b110, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL zero_done_cycle got done=%b busy=%b rdy=%b we=%b cnt=%0d required 1 1 0 0 0",
               done, busy, bus.in_ready, bus.mem_we, cnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({done, busy, cnt} !== 10'd0 || wr_a.size() != w0 || acc.size() != a0) begin
      miscompares++;
      $display("FAIL zero_after got done=%b busy=%b cnt=%0d writes=%0d bytes=%0d required 0 0 0 0 0",
               done, busy, cnt, wr_a.size() - w0, acc.size() - a0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] b[$];
    int w0, d0;
    bit ok;
    w0 = wr_a.size(); d0 = n_done;
    b = '{8'h11, 8'h22};
    do_start(8'h05, 8'd2);
    drive_bytes(b, 0);
    abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h99;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      miscompares++; $display("FAIL abort_ready got rdy=%b we=%b required 0 0", bus.in_ready, bus.mem_we);
    end
    @(posedge clk); #1;
    abort = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || wr_a.size() != w0) begin
      miscompares++; $display("FAIL abort_idle got busy=%b writes=%0d required 0 0", busy, wr_a.size() - w0);
    end
    // start with abort held in IDLE must still begin a load
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    abort = 1'b1;
    do_start(8'h20, 8'd1);
    abort = 1'b0;
    drive_bytes(b, 0);
    wait_idle(ok);
    vectors++;
    if (!ok || wr_a.size() - w0 != 1) begin
      miscompares++; $display("FAIL abort_restart_nwrites got %0d required 1", wr_a.size() - w0);
    end else begin
      vectors++;
      if (wr_a[w0] !== 8'h20 || wr_d[w0] !== 32'hDDCCBBAA) begin
        miscompares++; $display("FAIL abort_restart_wr got %h@%h required ddccbbaa@20", wr_d[w0], wr_a[w0]);
      end
    end
    vectors++;
    if (n_done - d0 != 1 || cnt !== 8'd1) begin
      miscompares++; $display("FAIL abort_restart_done got %0d pulses cnt=%0d required 1 1", n_done - d0, cnt);
    end
  endtask

  task automatic test_abort_write();
    logic [7:0] b[$];
    int w0, d0;
    w0 = wr_a.size(); d0 = n_done;
    b = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_start(8'h33, 8'd1);
    drive_bytes(b, 0);
    abort = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL abort_write_we got %b required 0", bus.mem_we); end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || cnt !== 8'd0 || wr_a.size() != w0 || n_done != d0) begin
      miscompares++;
      $display("FAIL abort_write_after got busy=%b cnt=%0d writes=%0d done=%0d required 0 0 0 0",
               busy, cnt, wr_a.size() - w0, n_done - d0);
    end
  endtask

  task automatic test_reset_stray();
    logic [7:0] b[$], h[$], t[$];
    int w0;
    bit ok;
    b = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    h = b[0:1]; t = b[2:7];
    w0 = wr_a.size();
    do_start(8'h30, 8'd2);
    drive_bytes(h, 0);
    start = 1'b1; base_a = 8'h50; len = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_bytes(t, 2);
    wait_idle(ok);
    vectors++;
    if (!ok || wr_a.size() - w0 != 2 || cnt !== 8'd2) begin
      miscompares++; $display("FAIL stray_nwrites got %0d cnt=%0d required 2 2", wr_a.size() - w0, cnt);
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (wr_a[w0+i] !== 8'(8'h30 + i) || wr_d[w0+i] !== exp_word(b, i)) begin
          miscompares++;
          $display("FAIL stray_wr%0d got %h@%h required %h@%h", i, wr_d[w0+i], wr_a[w0+i], exp_word(b, i), 8'(8'h30 + i));
        end
      end
    end
    h = '{8'hE1, 8'hE2, 8'hE3};
    do_start(8'h60, 8'd2);
    drive_bytes(h, 0);
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.mem_we, bus.mem_a, bus.mem_d, cpu_hold, busy, done, cnt} !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs got rdy=%b we=%b a=%h d=%h hold=%b busy=%b done=%b cnt=%h required all 0",
               bus.in_ready, bus.mem_we, bus.mem_a, bus.mem_d, cpu_hold, busy, done, cnt);
    end
    bus.in_valid = 1'b0;
    t = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
    w0 = wr_a.size();
    do_start(8'h70, 8'd1);
    drive_bytes(t, 0);
    wait_idle(ok);
    vectors++;
    if (!ok || wr_a.size() - w0 != 1) begin
      miscompares++; $display("FAIL midrst_reload_nwrites got %0d required 1", wr_a.size() - w0);
    end else begin
      vectors++;
      if (wr_a[w0] !== 8'h70 || wr_d[w0] !== 32'h0A0B0C0D) begin
        miscompares++; $display("FAIL midrst_reload_wr got %h@%h required 0a0b0c0d@70", wr_d[w0], wr_a[w0]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    logic [7:0] rb, rl;
    int w0, d0;
    bit ok;
    for (int it = 0; it < 8; it++) begin
      rb = 8'($urandom); rl = 8'($urandom_range(1, 4));
      b = {};
      for (int k = 0; k < 4 * rl; k++) b.push_back(8'($urandom));
      w0 = wr_a.size(); d0 = n_done;
      do_start(rb, rl);
      drive_bytes(b, 2);
      wait_idle(ok);
      vectors++;
      if (!ok || wr_a.size() - w0 != rl || n_done - d0 != 1 || cnt !== rl) begin
        miscompares++;
        $display("FAIL rand%0d_summary got writes=%0d done=%0d cnt=%0d required %0d 1 %0d",
                 it, wr_a.size() - w0, n_done - d0, cnt, rl, rl);
      end else begin
        for (int i = 0; i < rl; i++) begin
          vectors++;
          if (wr_a[w0+i] !== 8'(rb + i) || wr_d[w0+i] !== exp_word(b, i)) begin
            miscompares++;
            $display("FAIL rand%0d_wr%0d got %h@%h required %h@%h", it, i, wr_d[w0+i], wr_a[w0+i], exp_word(b, i), 8'(rb + i));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(1, "gapped");
    test_wrap();
    test_zero_len();
    test_abort();
    test_abort_write();
    test_reset_stray();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
